// File: rtl/clk_step_ctrl.sv
// Run/single-step clock-enable controller: synchronises and debounces the board
// controls and drives the processor clock enable. Optional burst stepping: STEP_BURST_EN.
`timescale 1ns/1ps

module clk_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 32
`ifdef STEP_BURST_EN
  , parameter int unsigned BURST_LEN     = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_step,
  input  logic             clk_select,
  output logic             cpu_en,
  output logic             step_mode,
  output logic             busy,
  output logic [CNT_W-1:0] en_count
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
`ifdef STEP_BURST_EN
  localparam int unsigned BR_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PULSE = 2'd2,
    S_BURST = 2'd3
  } state_t;

  logic            r_step_s1;
  logic            r_step_s2;
  logic            r_sel_s1;
  logic            r_sel_s2;
  logic            r_step_db;
  logic            r_step_db_q;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_press;
  state_t          r_state;
`ifdef STEP_BURST_EN
  logic [BR_W-1:0] r_remain;
`endif

  logic w_step_diff;
  logic w_db_hit;

  // Two-flop synchronisers for both asynchronous board controls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_sel_s1  <= 1'b0;
      r_sel_s2  <= 1'b0;
    end else begin
      r_step_s1 <= clk_step;
      r_step_s2 <= r_step_s1;
      r_sel_s1  <= clk_select;
      r_sel_s2  <= r_sel_s1;
    end
  end

  assign step_mode   = r_sel_s2;
  assign w_step_diff = r_step_s2 ^ r_step_db;
  assign w_db_hit    = w_step_diff && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

  // Debounce: level flips only after an unbroken run of differing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_db   <= 1'b0;
      r_step_db_q <= 1'b0;
      r_db_cnt    <= '0;
      r_press     <= 1'b0;
    end else begin
      r_step_db_q <= r_step_db;
      r_press     <= r_step_db & ~r_step_db_q;
      if (!w_step_diff) begin
        r_db_cnt <= '0;
      end else if (w_db_hit) begin
        r_step_db <= r_step_s2;
        r_db_cnt  <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  // Mode FSM; a press seen outside IDLE is simply not consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      cpu_en   <= 1'b0;
      busy     <= 1'b0;
`ifdef STEP_BURST_EN
      r_remain <= '0;
`endif
    end else begin
      case (r_state)
        S_RUN: begin
          busy <= 1'b0;
          if (r_sel_s2) begin
            r_state <= S_IDLE;
            cpu_en  <= 1'b0;
          end else begin
            cpu_en  <= 1'b1;
          end
        end
        S_IDLE: begin
          if (!r_sel_s2) begin
            r_state <= S_RUN;
            cpu_en  <= 1'b1;
            busy    <= 1'b0;
          end else if (r_press) begin
            r_state <= S_PULSE;
            cpu_en  <= 1'b1;
            busy    <= 1'b1;
          end else begin
            cpu_en  <= 1'b0;
            busy    <= 1'b0;
          end
        end
        S_PULSE: begin
`ifdef STEP_BURST_EN
          if (BURST_LEN > 1) begin
            r_remain <= BR_W'(BURST_LEN - 1);
            r_state  <= S_BURST;
            cpu_en   <= 1'b1;
            busy     <= 1'b1;
          end else begin
            r_state  <= S_IDLE;
            cpu_en   <= 1'b0;
            busy     <= 1'b0;
          end
`else
          r_state <= S_IDLE;
          cpu_en  <= 1'b0;
          busy    <= 1'b0;
`endif
        end
`ifdef STEP_BURST_EN
        S_BURST: begin
          if (r_remain == BR_W'(1)) begin
            r_remain <= '0;
            r_state  <= S_IDLE;
            cpu_en   <= 1'b0;
            busy     <= 1'b0;
          end else begin
            r_remain <= r_remain - BR_W'(1);
            cpu_en   <= 1'b1;
            busy     <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          cpu_en  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Enabled-cycle counter, wraps naturally at the register width
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_count <= '0;
    end else if (cpu_en) begin
      en_count <= en_count + CNT_W'(1);
    end
  end

endmodule
